// File: rtl/stage_execute_pkg.sv
// Shared types and constants for the execute stage: ALU op encoding, divider FSM states,
// bubble values and the branch-condition helper.
package stage_execute_pkg;

  localparam int unsigned DIV_CYCLES = 32;

  localparam logic [4:0] NOP_RD        = 5'd0;
  localparam logic       NOP_WR_ENABLE = 1'b0;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9,
    AluLui  = 4'd10
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivBusy = 2'd1,
    DivDone = 2'd2
  } div_state_e;

  function automatic logic branch_taken(input logic [2:0]  funct3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic taken;
    case (funct3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) < $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      3'b110:  taken = (a < b);
      3'b111:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// RV32M unit: single-cycle multiplier and a radix-2 restoring divider with an
// IDLE/BUSY/DONE handshake (start in, busy/done out).
module muldiv_unit
  import stage_execute_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e state_q, state_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [4:0]      count_q, count_d;
  logic            quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d, is_rem_q, is_rem_d;

  logic            op_signed;
  logic [XLEN:0]   rem_shift, rem_sub;
  logic            rem_ge;
  logic            mul_a_sign, mul_b_sign;
  logic [2*XLEN-1:0] mul_a, mul_b, product;

  // Lower 2*XLEN bits of the extended product are exact for every signedness mix.
  assign mul_a_sign = (funct3[1:0] != 2'b11) & op_a[XLEN-1];
  assign mul_b_sign = (funct3[1:0] == 2'b01) & op_b[XLEN-1];
  assign mul_a      = {{XLEN{mul_a_sign}}, op_a};
  assign mul_b      = {{XLEN{mul_b_sign}}, op_b};
  assign product    = mul_a * mul_b;

  assign op_signed = ~funct3[0];
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
  assign rem_sub   = rem_shift - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    count_d   = count_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    is_rem_d  = is_rem_q;
    unique case (state_q)
      DivIdle: begin
        if (start) begin
          state_d   = DivBusy;
          count_d   = '0;
          rem_d     = '0;
          quo_d     = (op_signed & op_a[XLEN-1]) ? -op_a : op_a;
          dvs_d     = (op_signed & op_b[XLEN-1]) ? -op_b : op_b;
          // Divide-by-zero keeps the all-ones quotient unsigned-looking.
          quo_neg_d = op_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]) & (|op_b);
          rem_neg_d = op_signed & op_a[XLEN-1];
          is_rem_d  = funct3[1];
        end
      end
      DivBusy: begin
        quo_d   = {quo_q[XLEN-2:0], rem_ge};
        rem_d   = rem_ge ? rem_sub[XLEN-1:0] : rem_shift[XLEN-1:0];
        count_d = count_q + 5'd1;
        if (count_q == 5'(DIV_CYCLES - 1)) state_d = DivDone;
      end
      DivDone: state_d = DivIdle;
      default: state_d = DivIdle;
    endcase
    if (flush) state_d = DivIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DivIdle;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      count_q   <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      count_q   <= count_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      is_rem_q  <= is_rem_d;
    end
  end

  assign busy = (state_q == DivBusy);
  assign done = (state_q == DivDone);

  always_comb begin
    if (!funct3[2]) begin
      result = (funct3[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
    end else if (is_rem_q) begin
      result = rem_neg_q ? -rem_q : rem_q;
    end else begin
      result = quo_neg_q ? -quo_q : quo_q;
    end
  end

endmodule

// File: rtl/stage_execute.sv
// RV32IM execute stage: inline ALU and branch resolution, muldiv_unit for M ops, and the
// registered interface to the memory stage with stall/flush bubbles.
module stage_execute
  import stage_execute_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [XLEN-1:0] decode_rs1_data,
  input  logic [XLEN-1:0] decode_rs2_data,
  input  logic [XLEN-1:0] decode_imm,
  input  logic [XLEN-1:0] decode_instr_addr,
  input  logic [4:0]      decode_rd,
  input  logic [2:0]      decode_funct3,
  input  logic [3:0]      decode_alu_ctrl,
  input  logic            decode_alu_src,
  input  logic            decode_muldiv,
  input  logic            decode_branch,
  input  logic            decode_jump,
  input  logic            decode_jalr,
  input  logic            decode_regfile_wr_enable,
  input  logic            decode_datamem_wr_enable,
  input  logic [1:0]      decode_result_src,
  output logic [4:0]      execute_rd,
  output logic            execute_regfile_wr_enable,
  output logic [XLEN-1:0] execute_alu_result,
  output logic [XLEN-1:0] execute_instr_addr_plus,
  output logic [1:0]      execute_result_src,
  output logic            execute_datamem_wr_enable,
  output logic [2:0]      execute_funct3,
  output logic [XLEN-1:0] execute_wr_datamem_data,
  output logic            execute_pc_src,
  output logic [XLEN-1:0] execute_branch_target,
  output logic            execute_stall
);

  logic [XLEN-1:0] alu_b, alu_result, md_result, exec_result, jalr_sum;
  logic [4:0]      shamt;
  logic            is_div, md_busy, md_done, bubble;

  always_comb begin
    alu_b = decode_alu_src ? decode_imm : decode_rs2_data;
    shamt = alu_b[4:0];
    case (alu_ctrl_e'(decode_alu_ctrl))
      AluAdd:  alu_result = decode_rs1_data + alu_b;
      AluSub:  alu_result = decode_rs1_data - alu_b;
      AluAnd:  alu_result = decode_rs1_data & alu_b;
      AluOr:   alu_result = decode_rs1_data | alu_b;
      AluXor:  alu_result = decode_rs1_data ^ alu_b;
      AluSll:  alu_result = decode_rs1_data << shamt;
      AluSrl:  alu_result = decode_rs1_data >> shamt;
      AluSra:  alu_result = $signed(decode_rs1_data) >>> shamt;
      AluSlt:  alu_result = {{(XLEN-1){1'b0}}, $signed(decode_rs1_data) < $signed(alu_b)};
      AluSltu: alu_result = {{(XLEN-1){1'b0}}, decode_rs1_data < alu_b};
      AluLui:  alu_result = alu_b;
      default: alu_result = '0;
    endcase
  end

  assign is_div = decode_muldiv & decode_funct3[2];

  muldiv_unit #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (is_div & ~flush),
    .funct3 (decode_funct3),
    .op_a   (decode_rs1_data),
    .op_b   (decode_rs2_data),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  // The held division stalls from its first cycle until the DONE cycle; flush overrides.
  assign execute_stall = ~rst & ~flush & (md_busy | (is_div & ~md_done));
  assign bubble        = flush | execute_stall;
  assign exec_result   = decode_muldiv ? md_result : alu_result;

  assign jalr_sum              = decode_rs1_data + decode_imm;
  assign execute_branch_target = decode_jalr ? {jalr_sum[XLEN-1:1], 1'b0}
                                             : decode_instr_addr + decode_imm;
  assign execute_pc_src = ~bubble & (decode_jump |
                          (decode_branch &
                           branch_taken(decode_funct3, decode_rs1_data, decode_rs2_data)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bubble) begin
      if (rst) begin
        execute_rd                <= '0;
        execute_regfile_wr_enable <= 1'b0;
        execute_datamem_wr_enable <= 1'b0;
      end else begin
        execute_rd                <= NOP_RD;
        execute_regfile_wr_enable <= NOP_WR_ENABLE;
        execute_datamem_wr_enable <= NOP_WR_ENABLE;
      end
      execute_alu_result      <= '0;
      execute_instr_addr_plus <= '0;
      execute_result_src      <= '0;
      execute_funct3          <= '0;
      execute_wr_datamem_data <= '0;
    end else begin
      execute_rd                <= decode_rd;
      execute_regfile_wr_enable <= decode_regfile_wr_enable;
      execute_datamem_wr_enable <= decode_datamem_wr_enable;
      execute_alu_result        <= exec_result;
      execute_instr_addr_plus   <= decode_instr_addr + XLEN'(4);
      execute_result_src        <= decode_result_src;
      execute_funct3            <= decode_funct3;
      execute_wr_datamem_data   <= decode_rs2_data;
    end
  end

endmodule

// File: tb/tb_stage_execute.sv
// Randomized self-checking bench for stage_execute against a plain-arithmetic RV32IM model.
module tb_stage_execute;
  import stage_execute_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] decode_rs1_data, decode_rs2_data, decode_imm, decode_instr_addr;
  logic [4:0]  decode_rd;
  logic [2:0]  decode_funct3;
  logic [3:0]  decode_alu_ctrl;
  logic        decode_alu_src, decode_muldiv, decode_branch, decode_jump, decode_jalr;
  logic        decode_regfile_wr_enable, decode_datamem_wr_enable;
  logic [1:0]  decode_result_src;
  logic [4:0]  execute_rd;
  logic        execute_regfile_wr_enable, execute_datamem_wr_enable;
  logic [31:0] execute_alu_result, execute_instr_addr_plus, execute_wr_datamem_data;
  logic [31:0] execute_branch_target;
  logic [1:0]  execute_result_src;
  logic [2:0]  execute_funct3;
  logic        execute_pc_src, execute_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stage_execute #(.XLEN(32)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .flush                     (flush),
    .decode_rs1_data           (decode_rs1_data),
    .decode_rs2_data           (decode_rs2_data),
    .decode_imm                (decode_imm),
    .decode_instr_addr         (decode_instr_addr),
    .decode_rd                 (decode_rd),
    .decode_funct3             (decode_funct3),
    .decode_alu_ctrl           (decode_alu_ctrl),
    .decode_alu_src            (decode_alu_src),
    .decode_muldiv             (decode_muldiv),
    .decode_branch             (decode_branch),
    .decode_jump               (decode_jump),
    .decode_jalr               (decode_jalr),
    .decode_regfile_wr_enable  (decode_regfile_wr_enable),
    .decode_datamem_wr_enable  (decode_datamem_wr_enable),
    .decode_result_src         (decode_result_src),
    .execute_rd                (execute_rd),
    .execute_regfile_wr_enable (execute_regfile_wr_enable),
    .execute_alu_result        (execute_alu_result),
    .execute_instr_addr_plus   (execute_instr_addr_plus),
    .execute_result_src        (execute_result_src),
    .execute_datamem_wr_enable (execute_datamem_wr_enable),
    .execute_funct3            (execute_funct3),
    .execute_wr_datamem_data   (execute_wr_datamem_data),
    .execute_pc_src            (execute_pc_src),
    .execute_branch_target     (execute_branch_target),
    .execute_stall             (execute_stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa = a;
    int sb = b;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return 32'(sa >>> b[4:0]);
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_branch(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
    int sa = a;
    int sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    case (f3[1:0])
      2'd0: p = longint'(int'(a)) * longint'(int'(b));
      2'd1: p = longint'(int'(a)) * longint'(int'(b));
      2'd2: p = longint'(int'(a)) * longint'({32'd0, b});
      default: begin
        pu = {32'd0, a} * {32'd0, b};
        p  = longint'(pu);
      end
    endcase
    return (f3[1:0] == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    int  sa = a;
    int  sb = b;
    logic is_rem = f3[1];
    logic sgn    = ~f3[0];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : a;
    if (sgn) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    return is_rem ? a % b : a / b;
  endfunction

  task automatic nop();
    flush = 0; decode_rs1_data = 0; decode_rs2_data = 0; decode_imm = 0;
    decode_instr_addr = 0; decode_rd = 0; decode_funct3 = 0; decode_alu_ctrl = 0;
    decode_alu_src = 0; decode_muldiv = 0; decode_branch = 0; decode_jump = 0;
    decode_jalr = 0; decode_regfile_wr_enable = 0; decode_datamem_wr_enable = 0;
    decode_result_src = 0;
  endtask

  // Checks one single-cycle instruction already on the decode_* inputs.
  task automatic check_single(input string tag);
    logic [31:0] b, exp_res, exp_tgt;
    logic        exp_pc;
    #1;
    b       = decode_alu_src ? decode_imm : decode_rs2_data;
    exp_res = decode_muldiv ? ref_mul(decode_funct3, decode_rs1_data, decode_rs2_data)
                            : ref_alu(decode_alu_ctrl, decode_rs1_data, b);
    exp_pc  = decode_jump | (decode_branch &
              ref_branch(decode_funct3, decode_rs1_data, decode_rs2_data));
    exp_tgt = decode_jalr ? ((decode_rs1_data + decode_imm) & 32'hFFFF_FFFE)
                          : decode_instr_addr + decode_imm;
    check_eq({tag, "_stall"}, 32'(execute_stall), 32'd0);
    check_eq({tag, "_pc_src"}, 32'(execute_pc_src), 32'(exp_pc));
    check_eq({tag, "_target"}, execute_branch_target, exp_tgt);
    @(posedge clk); #1;
    check_eq({tag, "_result"}, execute_alu_result, exp_res);
    check_eq({tag, "_rd"}, 32'(execute_rd), 32'(decode_rd));
    check_eq({tag, "_rf_we"}, 32'(execute_regfile_wr_enable), 32'(decode_regfile_wr_enable));
    check_eq({tag, "_dm_we"}, 32'(execute_datamem_wr_enable), 32'(decode_datamem_wr_enable));
    check_eq({tag, "_pc4"}, execute_instr_addr_plus, decode_instr_addr + 32'd4);
    check_eq({tag, "_rsrc"}, 32'(execute_result_src), 32'(decode_result_src));
    check_eq({tag, "_f3"}, 32'(execute_funct3), 32'(decode_funct3));
    check_eq({tag, "_wdata"}, execute_wr_datamem_data, decode_rs2_data);
  endtask

  // Waits out a division already on decode_*: counts stall cycles, checks bubbles and result.
  task automatic div_wait(input string tag, input logic [31:0] exp_res, input logic [4:0] rd);
    int n = 0;
    #1;
    while (execute_stall && n < 40) begin
      n++;
      @(posedge clk); #1;
      check_eq({tag, "_bubble_rd"}, 32'(execute_rd), 32'd0);
      check_eq({tag, "_bubble_we"}, 32'(execute_regfile_wr_enable), 32'd0);
    end
    check_eq({tag, "_stall_cycles"}, n, DIV_CYCLES + 1);
    @(posedge clk); #1;
    check_eq({tag, "_result"}, execute_alu_result, exp_res);
    check_eq({tag, "_rd"}, 32'(execute_rd), 32'(rd));
    check_eq({tag, "_we"}, 32'(execute_regfile_wr_enable), 32'd1);
  endtask

  task automatic run_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b);
    logic [4:0] rd = 5'($urandom_range(1, 31));
    nop();
    decode_muldiv = 1; decode_funct3 = f3; decode_rs1_data = a; decode_rs2_data = b;
    decode_rd = rd; decode_regfile_wr_enable = 1;
    div_wait(tag, ref_div(f3, a, b), rd);
    nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    nop();
    rst = 1;
    #1;
    check_eq("reset_result", execute_alu_result, 32'd0);
    check_eq("reset_rd", 32'(execute_rd), 32'd0);
    check_eq("reset_we", 32'(execute_regfile_wr_enable), 32'd0);
    check_eq("reset_pc4", execute_instr_addr_plus, 32'd0);
    decode_muldiv = 1; decode_funct3 = 3'b100; decode_rs2_data = 3;
    #1;
    check_eq("reset_stall", 32'(execute_stall), 32'd0);
    nop();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // ADD with negative immediate, then asynchronous reset clears it mid-cycle.
    decode_alu_ctrl = AluAdd; decode_rs1_data = 5; decode_imm = 32'hFFFF_FFF9;
    decode_alu_src = 1; decode_rd = 7; decode_regfile_wr_enable = 1;
    check_single("add");
    check_eq("add_direct", execute_alu_result, 32'hFFFF_FFFE);
    #2 rst = 1;
    #1;
    check_eq("async_rst_result", execute_alu_result, 32'd0);
    check_eq("async_rst_rd", 32'(execute_rd), 32'd0);
    check_eq("async_rst_we", 32'(execute_regfile_wr_enable), 32'd0);
    rst = 0;
    nop();
    @(posedge clk); #1;

    // BLT taken, BLTU not taken on the same operands.
    decode_branch = 1; decode_funct3 = 3'b100; decode_rs1_data = 32'hFFFF_FFFF;
    decode_rs2_data = 1; decode_instr_addr = 32'h100; decode_imm = 32'h20;
    #1;
    check_eq("blt_pc_src", 32'(execute_pc_src), 32'd1);
    check_eq("blt_target", execute_branch_target, 32'h120);
    check_single("blt");
    decode_funct3 = 3'b110;
    #1;
    check_eq("bltu_pc_src", 32'(execute_pc_src), 32'd0);
    check_single("bltu");
    nop();

    run_div("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2);
    check_eq("div_neg_direct", execute_alu_result, 32'hFFFF_FFFD);
    run_div("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2);
    check_eq("rem_neg_direct", execute_alu_result, 32'hFFFF_FFFF);
    run_div("divu_zero", 3'b101, 32'd100, 32'd0);
    check_eq("divu_zero_direct", execute_alu_result, 32'hFFFF_FFFF);
    run_div("remu_zero", 3'b111, 32'd100, 32'd0);
    check_eq("remu_zero_direct", execute_alu_result, 32'd100);
    run_div("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("div_ovf_direct", execute_alu_result, 32'h8000_0000);
    run_div("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("div_negzero", 3'b100, 32'hFFFF_FFF0, 32'd0);

    // Flush ten cycles into a division, then a single-cycle ADD and a fresh division.
    decode_muldiv = 1; decode_funct3 = 3'b100; decode_rs1_data = 50; decode_rs2_data = 5;
    decode_rd = 4; decode_regfile_wr_enable = 1;
    repeat (10) begin @(posedge clk); #1; end
    decode_jump = 1; flush = 1;
    #1;
    check_eq("flush_stall", 32'(execute_stall), 32'd0);
    check_eq("flush_pc_src", 32'(execute_pc_src), 32'd0);
    @(posedge clk); #1;
    check_eq("flush_bubble_rd", 32'(execute_rd), 32'd0);
    check_eq("flush_bubble_we", 32'(execute_regfile_wr_enable), 32'd0);
    nop();
    decode_alu_ctrl = AluAdd; decode_rs1_data = 3; decode_rs2_data = 4;
    decode_rd = 9; decode_regfile_wr_enable = 1;
    check_single("post_flush_add");
    run_div("post_flush_div", 3'b101, 32'd1000, 32'd9);

    // Reset in the middle of a division; the held division restarts with full latency.
    decode_muldiv = 1; decode_funct3 = 3'b101; decode_rs1_data = 1000; decode_rs2_data = 7;
    decode_rd = 3; decode_regfile_wr_enable = 1;
    repeat (5) begin @(posedge clk); #1; end
    #1 rst = 1;
    #1;
    check_eq("mid_rst_stall", 32'(execute_stall), 32'd0);
    check_eq("mid_rst_rd", 32'(execute_rd), 32'd0);
    #1 rst = 0;
    div_wait("div_after_rst", 32'd142, 5'd3);
    nop();
    decode_jump = 1; decode_jalr = 1; decode_rs1_data = 32'h1001; decode_imm = 2;
    decode_instr_addr = 32'h200; decode_rd = 1; decode_regfile_wr_enable = 1;
    decode_result_src = 2;
    #1;
    check_eq("jalr_target", execute_branch_target, 32'h1002);
    check_single("jalr");
    check_eq("jalr_pc4", execute_instr_addr_plus, 32'h204);
    nop();

    for (int i = 0; i < 300; i++) begin
      decode_rs1_data   = $urandom;
      decode_rs2_data   = ($urandom_range(0, 3) == 0) ? decode_rs1_data : $urandom;
      decode_imm        = $urandom;
      decode_instr_addr = $urandom;
      decode_rd         = 5'($urandom);
      decode_funct3     = 3'($urandom);
      decode_alu_ctrl   = 4'($urandom_range(0, 10));
      decode_alu_src    = 1'($urandom);
      decode_muldiv     = ($urandom_range(0, 3) == 0);
      if (decode_muldiv) decode_funct3[2] = 1'b0;
      decode_branch     = 1'($urandom);
      decode_jump       = ($urandom_range(0, 7) == 0);
      decode_jalr       = 1'($urandom);
      decode_regfile_wr_enable = 1'($urandom);
      decode_datamem_wr_enable = 1'($urandom);
      decode_result_src        = 2'($urandom);
      check_single("rand");
    end
    nop();

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = (i < 2) ? 32'($urandom_range(1, 100)) : $urandom;
      if (i == 5) b = {32{1'b1}};
      run_div("rand_div", 3'($urandom_range(4, 7)), a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_execute.md
STAGE_EXECUTE -- requirements
Module: stage_execute

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port flush  input  1  squash the instruction in execute, abort any division.
REQ-005 SHALL have ports decode_rs1_data, decode_rs2_data, decode_imm, decode_instr_addr  input  32 each  operands (already forwarded), immediate, instruction PC.
REQ-006 SHALL have ports decode_rd  input  5 and decode_funct3  input  3  destination register and funct3.
REQ-007 SHALL have port decode_alu_ctrl  input  4  ALU operation (pkg enum); decode_alu_src  input  1  0=rs2, 1=imm.
REQ-008 SHALL have inputs decode_muldiv, decode_branch, decode_jump, decode_jalr, decode_regfile_wr_enable, decode_datamem_wr_enable  1 bit each; decode_result_src  input  2.
REQ-009 SHALL have registered outputs execute_rd 5, execute_regfile_wr_enable 1, execute_alu_result 32, execute_instr_addr_plus 32, execute_result_src 2, execute_datamem_wr_enable 1, execute_funct3 3, execute_wr_datamem_data 32, all feeding the memory stage.
REQ-010 SHALL have combinational outputs execute_pc_src 1, execute_branch_target 32, execute_stall 1.

Function
REQ-011 Non-muldiv ops SHALL have 1-cycle latency: result registered on the edge after presentation.
REQ-012 ALU ops SHALL be ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, LUI-pass (B); shift amount = B[4:0]; B = imm if alu_src else rs2.
REQ-013 execute_wr_datamem_data SHALL be rs2; execute_instr_addr_plus SHALL be instr_addr+4 (mod 2^32).
REQ-014 Branch condition SHALL follow funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; others false.
REQ-015 execute_pc_src SHALL = jump OR (branch AND condition), forced 0 while flush or stall.
REQ-016 execute_branch_target SHALL be (rs1+imm)&~1 when jalr, else instr_addr+imm.
REQ-017 muldiv funct3 000-011 (MUL, MULH, MULHSU, MULHU) SHALL complete in 1 cycle, full 64-bit product, upper/lower per RV32M.
REQ-018 muldiv funct3 100-111 (DIV, DIVU, REM, REMU) SHALL use a radix-2 restoring FSM: IDLE, BUSY, DONE.
REQ-019 Division presented in cycle N: stall high cycles N..N+32 (IDLE->BUSY at N's edge, 32 BUSY iterations, BUSY->DONE), stall low in N+33 (DONE), result registered at the edge ending N+33, DONE->IDLE.
REQ-020 Upstream holds decode_* stable while execute_stall=1; block SHALL register a bubble (both write enables 0, rd 0) each stalled cycle.
REQ-021 Divide by zero SHALL give quotient 0xFFFFFFFF, remainder = dividend; DIV/REM of 0x80000000 by -1 SHALL give 0x80000000 / 0; both SHALL take full latency.
REQ-022 Signed division SHALL divide magnitudes, quotient negated if signs differ, remainder takes dividend sign.
REQ-023 flush SHALL register a bubble next edge and force FSM to IDLE from any state; flush wins over stall.
REQ-024 Back-to-back divisions SHALL each incur full latency; no result reuse.

Reset
REQ-025 rst high SHALL immediately clear every registered output to 0 and FSM to IDLE; execute_stall SHALL read 0 during reset.
REQ-026 rst asserted mid-division SHALL discard it; after release the held instruction restarts from IDLE.

Structure
REQ-027 A shared package SHALL hold the alu_ctrl enum, divider state enum, and constants (DIV_CYCLES=32, NOP bubble values).
REQ-028 Divider SHALL be sub-module muldiv_unit (start/busy/done handshake, IDLE/BUSY/DONE FSM); ALU and branch compare stay inline.

Verification
REQ-029 ADD rs1=5, imm=-7 (alu_src=1) -> execute_alu_result=0xFFFFFFFE next edge, rd/wr_enable passed.
REQ-030 BLT rs1=0xFFFFFFFF, rs2=1, instr_addr=0x100, imm=0x20 -> pc_src=1, target=0x120 same cycle; BLTU same operands -> pc_src=0.
REQ-031 DIV 0xFFFFFFF9 by 2 -> stall high exactly 33 cycles, bubbles registered, then result 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-032 DIVU 100 by 0 -> 0xFFFFFFFF; REMU -> 100; DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000.
REQ-033 flush at cycle 10 of a division -> stall low next cycle, bubble registered, next ADD completes in 1 cycle.
REQ-034 rst pulse mid-division -> all outputs 0 asynchronously, FSM IDLE; JALR rs1=0x1001, imm=2 afterwards -> target 0x1002, instr_addr_plus=pc+4.
